// File: rtl/sparse_acc_pkg.sv
// rtl/sparse_acc_pkg.sv - shared state encoding and lane field layout for sparse_accum_router
package sparse_acc_pkg;

    typedef enum logic [1:0] {
        ACCUM = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int LIMIT_W = 5;
    localparam int DROP_W  = 16;

    // Lane word is {prod, row, col} with col in the low bits.
    localparam int COL_OFF = 0;

    function automatic int row_off(input int crd_w);
        return crd_w;
    endfunction

    function automatic int prod_off(input int crd_w);
        return 2 * crd_w;
    endfunction

    function automatic int lane_w(input int prod_w, input int crd_w);
        return prod_w + 2 * crd_w;
    endfunction

endpackage

// File: rtl/accum_lane_merge.sv
// rtl/accum_lane_merge.sv - sums every enabled lane that targets one accumulator entry
module accum_lane_merge
    import sparse_acc_pkg::*;
#(
    parameter int NUM_LANES = 4,
    parameter int PROD_W    = 16,
    parameter int CRD_W     = 4,
    parameter int SUM_W     = 23
) (
    input  logic [NUM_LANES-1:0]                  lane_en,
    input  logic [NUM_LANES*(PROD_W+2*CRD_W)-1:0] lane_data,
    input  logic [CRD_W-1:0]                      row,
    input  logic [CRD_W-1:0]                      col,
    output logic signed [SUM_W-1:0]               sum,
    output logic                                  hit
);

    localparam int LW    = lane_w(PROD_W, CRD_W);
    localparam int R_OFF = row_off(CRD_W);
    localparam int P_OFF = prod_off(CRD_W);

    // Lanes already qualified as accepted and in-window; only the coordinate match remains.
    always_comb begin
        sum = '0;
        hit = 1'b0;
        for (int k = 0; k < NUM_LANES; k++) begin
            if (lane_en[k] &&
                lane_data[k*LW + R_OFF +: CRD_W] == row &&
                lane_data[k*LW + COL_OFF +: CRD_W] == col) begin
                sum = sum + SUM_W'($signed(lane_data[k*LW + P_OFF +: PROD_W]));
                hit = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sparse_accum_router.sv
// rtl/sparse_accum_router.sv - lane-merging accumulator array with row-major clearing readout
module sparse_accum_router
    import sparse_acc_pkg::*;
#(
    parameter int NUM_LANES = 4,
    parameter int PROD_W    = 16,
    parameter int ACC_W     = 20,
    parameter int OUT_DIM   = 12,
    parameter int SAT       = 1,
    parameter int CRD_W     = $clog2(OUT_DIM)
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic [4:0]                            limit,
    input  logic [NUM_LANES-1:0]                  in_valid,
    input  logic [NUM_LANES*(PROD_W+2*CRD_W)-1:0] in_data,
    output logic                                  in_ready,
    input  logic                                  drain_start,
    input  logic                                  clear,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic [ACC_W-1:0]                      out_data,
    output logic [CRD_W-1:0]                      out_row,
    output logic [CRD_W-1:0]                      out_col,
    output logic                                  out_last,
    output logic                                  done,
    output logic [15:0]                           drop_count
);

    localparam int LW    = lane_w(PROD_W, CRD_W);
    localparam int R_OFF = row_off(CRD_W);
    localparam int SUM_W = ACC_W + $clog2(NUM_LANES) + 1;
    localparam int NE    = OUT_DIM * OUT_DIM;
    localparam logic signed [SUM_W-1:0] ACC_MAX = {{(SUM_W-ACC_W+1){1'b0}}, {(ACC_W-1){1'b1}}};
    localparam logic signed [SUM_W-1:0] ACC_MIN = ~ACC_MAX;
    localparam logic [LIMIT_W-1:0] DIM_LIM = LIMIT_W'(OUT_DIM);

    state_t state, state_nxt;

    logic [LIMIT_W-1:0]   lim_q, lim_eff, win;
    logic [NUM_LANES-1:0] acc_lane, in_win, hit_en;
    logic                 do_clear, go_drain, handshake, last_hs;
    logic [NE*ACC_W-1:0]  cur_flat;
    logic [ACC_W-1:0]     first_nxt, rd_next;
    logic [CRD_W-1:0]     nr, nc;
    logic                 n_last, row_wrap;
    logic [31:0]          n_idx, drop_n, drop_sum;

    assign in_ready  = (state == ACCUM);
    assign done      = (state == DONE);
    assign acc_lane  = in_valid & {NUM_LANES{in_ready}};
    assign do_clear  = in_ready & clear;
    assign go_drain  = in_ready & drain_start & ~clear;
    assign handshake = out_valid & out_ready & (state == DRAIN);
    assign last_hs   = handshake & out_last;
    assign lim_eff   = (32'(limit) > 32'(OUT_DIM)) ? DIM_LIM : limit;
    assign win       = in_ready ? lim_eff : lim_q;
    // A clear in the same cycle discards all lanes, so no entry sees a hit.
    assign hit_en    = acc_lane & in_win & {NUM_LANES{~clear}};
    assign drop_sum  = 32'(drop_count) + drop_n;

    // Window test per lane and count of accepted lanes falling outside it.
    always_comb begin
        in_win = '0;
        drop_n = '0;
        for (int k = 0; k < NUM_LANES; k++) begin
            in_win[k] = (32'(in_data[k*LW + R_OFF +: CRD_W]) < 32'(win)) &&
                        (32'(in_data[k*LW + COL_OFF +: CRD_W]) < 32'(win));
            if (acc_lane[k] && !in_win[k]) begin
                drop_n = drop_n + 1;
            end
        end
    end

    // Next scan position within the latched window and the value waiting there.
    always_comb begin
        row_wrap = (32'(out_col) + 1 == 32'(lim_q));
        nr       = row_wrap ? out_row + CRD_W'(1) : out_row;
        nc       = row_wrap ? '0 : out_col + CRD_W'(1);
        n_last   = (32'(nr) + 1 == 32'(lim_q)) && (32'(nc) + 1 == 32'(lim_q));
        n_idx    = 32'(nr) * 32'(OUT_DIM) + 32'(nc);
        rd_next  = (n_idx < 32'(NE)) ? cur_flat[n_idx*ACC_W +: ACC_W] : '0;
    end

    for (genvar r = 0; r < OUT_DIM; r++) begin : g_row
        for (genvar c = 0; c < OUT_DIM; c++) begin : g_col
            logic signed [SUM_W-1:0] msum, wide;
            logic                    mhit;
            logic signed [ACC_W-1:0] q, nq;

            accum_lane_merge #(
                .NUM_LANES(NUM_LANES),
                .PROD_W   (PROD_W),
                .CRD_W    (CRD_W),
                .SUM_W    (SUM_W)
            ) u_merge (
                .lane_en  (hit_en),
                .lane_data(in_data),
                .row      (CRD_W'(r)),
                .col      (CRD_W'(c)),
                .sum      (msum),
                .hit      (mhit)
            );

            // Entry update: clear, merged add with optional saturation, or zero on readout.
            always_comb begin
                wide = SUM_W'($signed(q)) + msum;
                nq   = q;
                if (do_clear) begin
                    nq = '0;
                end else if (mhit) begin
                    if (SAT != 0 && wide > ACC_MAX) begin
                        nq = ACC_MAX[ACC_W-1:0];
                    end else if (SAT != 0 && wide < ACC_MIN) begin
                        nq = ACC_MIN[ACC_W-1:0];
                    end else begin
                        nq = wide[ACC_W-1:0];
                    end
                end else if (handshake && out_row == CRD_W'(r) && out_col == CRD_W'(c)) begin
                    nq = '0;
                end
            end

            // Entry storage.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    q <= '0;
                end else begin
                    q <= nq;
                end
            end

            assign cur_flat[(r*OUT_DIM + c)*ACC_W +: ACC_W] = q;

            // The first drained word must include lanes accepted with drain_start.
            if (r == 0 && c == 0) begin : g_first
                assign first_nxt = nq;
            end
        end
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ACCUM;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; an empty window skips the scan entirely.
    always_comb begin
        state_nxt = state;
        case (state)
            ACCUM: begin
                if (go_drain) begin
                    state_nxt = (lim_eff == '0) ? DONE : DRAIN;
                end
            end
            DRAIN: begin
                if (lim_q == '0 || last_hs) begin
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = ACCUM;
            default: state_nxt = ACCUM;
        endcase
    end

    // Readout registers: load (0,0) on drain start, advance on each handshake.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lim_q     <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_data  <= '0;
            out_row   <= '0;
            out_col   <= '0;
        end else if (go_drain) begin
            lim_q     <= lim_eff;
            out_valid <= (lim_eff != '0);
            out_last  <= (lim_eff == LIMIT_W'(1));
            out_data  <= first_nxt;
            out_row   <= '0;
            out_col   <= '0;
        end else if (handshake) begin
            if (out_last) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end else begin
                out_row  <= nr;
                out_col  <= nc;
                out_data <= rd_next;
                out_last <= n_last;
            end
        end
    end

    // Saturating drop counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            drop_count <= '0;
        end else if (do_clear) begin
            drop_count <= '0;
        end else if (drop_sum > 32'h0000_FFFF) begin
            drop_count <= 16'hFFFF;
        end else begin
            drop_count <= drop_sum[15:0];
        end
    end

endmodule

// File: tb/tb_sparse_accum_router.sv
// tb/tb_sparse_accum_router.sv - scoreboard bench for saturating and wrapping router instances
module tb_sparse_accum_router;

    localparam int NL   = 4;
    localparam int PW   = 16;
    localparam int AW   = 20;
    localparam int OD   = 12;
    localparam int CW   = 4;
    localparam int LW   = PW + 2 * CW;
    localparam int AMAX = (1 << (AW - 1)) - 1;
    localparam int AMIN = -(1 << (AW - 1));

    logic            clk = 1'b0;
    logic            reset;
    logic [4:0]      limit;
    logic [NL-1:0]   in_valid;
    logic [NL*LW-1:0] in_data;
    logic            drain_start, clear, out_ready;

    logic            a_in_ready, a_out_valid, a_out_last, a_done;
    logic [AW-1:0]   a_out_data;
    logic [CW-1:0]   a_out_row, a_out_col;
    logic [15:0]     a_drop_count;
    logic            b_in_ready, b_out_valid, b_out_last, b_done;
    logic [AW-1:0]   b_out_data;
    logic [CW-1:0]   b_out_row, b_out_col;
    logic [15:0]     b_drop_count;

    always #5 clk = ~clk;

    sparse_accum_router #(.NUM_LANES(NL), .PROD_W(PW), .ACC_W(AW), .OUT_DIM(OD), .SAT(1)) u_sat (
        .clk(clk), .reset(reset), .limit(limit), .in_valid(in_valid), .in_data(in_data),
        .in_ready(a_in_ready), .drain_start(drain_start), .clear(clear),
        .out_valid(a_out_valid), .out_ready(out_ready), .out_data(a_out_data),
        .out_row(a_out_row), .out_col(a_out_col), .out_last(a_out_last),
        .done(a_done), .drop_count(a_drop_count)
    );

    sparse_accum_router #(.NUM_LANES(NL), .PROD_W(PW), .ACC_W(AW), .OUT_DIM(OD), .SAT(0)) u_wrap (
        .clk(clk), .reset(reset), .limit(limit), .in_valid(in_valid), .in_data(in_data),
        .in_ready(b_in_ready), .drain_start(drain_start), .clear(clear),
        .out_valid(b_out_valid), .out_ready(out_ready), .out_data(b_out_data),
        .out_row(b_out_row), .out_col(b_out_col), .out_last(b_out_last),
        .done(b_done), .drop_count(b_drop_count)
    );

    typedef struct {
        int r;
        int c;
        int d;
        bit last;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    int   ma[OD][OD];
    int   mb[OD][OD];
    int   m_drop;
    int   checks = 0;
    int   failures = 0;
    int   lp[NL];
    int   lr[NL];
    int   lc[NL];
    bit   zero_flag = 1'b0;
    bit   exp_done[2];
    bit   stalled[2];
    int   hd[2];
    int   hr[2];
    int   hc[2];
    int   hl[2];
    int   rdy_mode = 0;
    int   rdy_cnt = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    function automatic int fix(input int x, input bit sat);
        if (sat) return (x > AMAX) ? AMAX : ((x < AMIN) ? AMIN : x);
        return ((x & ((1 << AW) - 1)) ^ (1 << (AW - 1))) - (1 << (AW - 1));
    endfunction

    function automatic int eff_of(input int l);
        return (l > OD) ? OD : l;
    endfunction

    task automatic model_zero();
        for (int r = 0; r < OD; r++)
            for (int c = 0; c < OD; c++) begin
                ma[r][c] = 0;
                mb[r][c] = 0;
            end
        m_drop = 0;
    endtask

    // Reference behaviour of one accepted cycle.
    task automatic model_update(input logic [NL-1:0] v, input bit clr, input bit ds);
        int e;
        int dl[OD][OD];
        bit hit[OD][OD];
        e = eff_of(int'(limit));
        if (clr) begin
            model_zero();
            return;
        end
        for (int r = 0; r < OD; r++)
            for (int c = 0; c < OD; c++) begin
                dl[r][c]  = 0;
                hit[r][c] = 1'b0;
            end
        for (int k = 0; k < NL; k++) begin
            if (v[k]) begin
                if (lr[k] < e && lc[k] < e) begin
                    dl[lr[k]][lc[k]] += lp[k];
                    hit[lr[k]][lc[k]] = 1'b1;
                end else if (m_drop < 65535) begin
                    m_drop++;
                end
            end
        end
        for (int r = 0; r < OD; r++)
            for (int c = 0; c < OD; c++)
                if (hit[r][c]) begin
                    ma[r][c] = fix(ma[r][c] + dl[r][c], 1'b1);
                    mb[r][c] = fix(mb[r][c] + dl[r][c], 1'b0);
                end
        if (ds) begin
            for (int r = 0; r < e; r++)
                for (int c = 0; c < e; c++) begin
                    qa.push_back('{r, c, ma[r][c], (r == e - 1 && c == e - 1)});
                    qb.push_back('{r, c, mb[r][c], (r == e - 1 && c == e - 1)});
                    ma[r][c] = 0;
                    mb[r][c] = 0;
                end
            if (e == 0) zero_flag = 1'b1;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        rdy_cnt++;
        case (rdy_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = (rdy_cnt % 4 == 0) || (rdy_cnt % 4 == 3);
            default: out_ready = 1'($urandom_range(0, 1));
        endcase
    endtask

    task automatic step(input logic [NL-1:0] v, input bit clr, input bit ds);
        in_valid    = v;
        clear       = clr;
        drain_start = ds;
        for (int k = 0; k < NL; k++)
            in_data[k*LW +: LW] = {PW'(lp[k]), CW'(lr[k]), CW'(lc[k])};
        model_update(v, clr, ds);
        tick();
        in_valid    = '0;
        clear       = 1'b0;
        drain_start = 1'b0;
        zero_flag   = 1'b0;
    endtask

    task automatic finish_drain(input int e);
        int n;
        if (e == 0) begin
            chk("zero_limit_done", int'(a_done), 1);
            chk("zero_limit_valid", int'(a_out_valid), 0);
        end else begin
            n = 0;
            while (!a_done && n < 3000) begin
                tick();
                n++;
            end
            chk("drain_done_within_budget", int'(a_done), 1);
        end
        tick();
        chk("in_ready_after_done", int'(a_in_ready), 1);
        chk("sat_queue_empty", qa.size(), 0);
        chk("wrap_queue_empty", qb.size(), 0);
        rdy_mode = 0;
    endtask

    task automatic drain_with(input logic [NL-1:0] v, input int lim, input int mode);
        limit    = 5'(lim);
        rdy_mode = mode;
        rdy_cnt  = -1;
        step(v, 1'b0, 1'b1);
        finish_drain(eff_of(lim));
    endtask

    task automatic set_lane(input int k, input int p, input int r, input int c);
        lp[k] = p;
        lr[k] = r;
        lc[k] = c;
    endtask

    // Per-instance output check: done timing, stall stability, scoreboard pop.
    task automatic mon(input int id, input logic v, input logic [AW-1:0] d, input logic [CW-1:0] r,
                       input logic [CW-1:0] c, input logic l, input logic dn);
        exp_t e;
        bit   empty;
        chk($sformatf("done_timing_%0d", id), int'(dn), int'(exp_done[id]));
        exp_done[id] = zero_flag;
        if (stalled[id] && v) begin
            chk($sformatf("hold_data_%0d", id), int'($signed(d)), hd[id]);
            chk($sformatf("hold_row_%0d", id), int'(r), hr[id]);
            chk($sformatf("hold_col_%0d", id), int'(c), hc[id]);
            chk($sformatf("hold_last_%0d", id), int'(l), hl[id]);
        end
        stalled[id] = v && !out_ready;
        hd[id] = int'($signed(d));
        hr[id] = int'(r);
        hc[id] = int'(c);
        hl[id] = int'(l);
        if (v && out_ready) begin
            empty = (id == 0) ? (qa.size() == 0) : (qb.size() == 0);
            if (empty) begin
                checks++;
                failures++;
                $display("FAIL unexpected_word_%0d actual=(%0d,%0d)=%0d expected=none", id, r, c, $signed(d));
            end else begin
                e = (id == 0) ? qa.pop_front() : qb.pop_front();
                chk($sformatf("row_%0d", id), int'(r), e.r);
                chk($sformatf("col_%0d", id), int'(c), e.c);
                chk($sformatf("data_%0d", id), int'($signed(d)), e.d);
                chk($sformatf("last_%0d", id), int'(l), int'(e.last));
                if (e.last) exp_done[id] = 1'b1;
            end
        end
    endtask

    // Monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (reset === 1'b0) begin
            mon(0, a_out_valid, a_out_data, a_out_row, a_out_col, a_out_last, a_done);
            mon(1, b_out_valid, b_out_data, b_out_row, b_out_col, b_out_last, b_done);
        end
    end

    task automatic do_reset();
        reset = 1'b1;
        qa.delete();
        qb.delete();
        model_zero();
        for (int i = 0; i < 2; i++) begin
            exp_done[i] = 1'b0;
            stalled[i]  = 1'b0;
        end
        in_valid = '0;
        clear = 1'b0;
        drain_start = 1'b0;
        #1;
        chk("reset_out_valid", int'(a_out_valid), 0);
        chk("reset_out_data", int'(a_out_data), 0);
        tick();
        tick();
        reset = 1'b0;
        tick();
        chk("reset_in_ready_sat", int'(a_in_ready), 1);
        chk("reset_in_ready_wrap", int'(b_in_ready), 1);
        chk("reset_out_valid_after", int'(a_out_valid), 0);
        chk("reset_out_last", int'(a_out_last), 0);
        chk("reset_done", int'(a_done), 0);
        chk("reset_out_row", int'(a_out_row), 0);
        chk("reset_out_col", int'(a_out_col), 0);
        chk("reset_drop_count", int'(a_drop_count), 0);
    endtask

    task automatic random_fill(input int n, input int maxc);
        for (int i = 0; i < n; i++) begin
            for (int k = 0; k < NL; k++)
                set_lane(k, int'($urandom_range(0, 65535)) - 32768,
                         int'($urandom_range(0, maxc)), int'($urandom_range(0, maxc)));
            step(NL'($urandom_range(0, (1 << NL) - 1)), 1'b0, 1'b0);
        end
    endtask

    initial begin
        reset = 1'b1;
        limit = '0;
        in_valid = '0;
        in_data = '0;
        drain_start = 1'b0;
        clear = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < NL; k++) set_lane(k, 0, 0, 0);
        do_reset();

        // Same-cycle merge of four identical lanes.
        limit = 5'd4;
        for (int k = 0; k < NL; k++) set_lane(k, 5, 2, 3);
        step('1, 1'b0, 1'b0);
        drain_with('0, 4, 0);

        // Window drop and drop_count saturation.
        limit = 5'd10;
        set_lane(0, 7, 10, 0);
        step(4'b0001, 1'b0, 1'b0);
        chk("drop_one", int'(a_drop_count), 1);
        for (int k = 0; k < NL; k++) set_lane(k, 9, 10, k);
        for (int i = 0; i < 17500; i++) step('1, 1'b0, 1'b0);
        chk("drop_saturated_sat", int'(a_drop_count), m_drop);
        chk("drop_saturated_wrap", int'(b_drop_count), 65535);
        drain_with('0, 10, 0);
        step('0, 1'b1, 1'b0);
        chk("drop_cleared", int'(a_drop_count), 0);

        // Saturation versus wrap on (0,0).
        limit = 5'd12;
        set_lane(0, 32767, 0, 0);
        for (int i = 0; i < 40; i++) step(4'b0001, 1'b0, 1'b0);
        drain_with('0, 1, 0);

        // Backpressure on a 2x2 window, then a re-drain of zeros.
        limit = 5'd2;
        for (int i = 0; i < 4; i++) begin
            set_lane(0, int'($urandom_range(1, 30000)), i / 2, i % 2);
            step(4'b0001, 1'b0, 1'b0);
        end
        drain_with('0, 2, 1);
        drain_with('0, 2, 1);

        // Lanes arriving with drain_start are part of the drain.
        limit = 5'd3;
        for (int k = 0; k < NL; k++)
            set_lane(k, int'($urandom_range(0, 2000)) - 1000, int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));
        drain_with('1, 3, 0);

        // clear beats drain_start.
        limit = 5'd4;
        random_fill(6, 3);
        step('1, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) begin
            chk("clear_wins_no_valid", int'(a_out_valid), 0);
            chk("clear_wins_in_ready", int'(a_in_ready), 1);
            tick();
        end
        drain_with('0, 4, 0);

        // Reset three words into a drain.
        limit = 5'd4;
        random_fill(10, 3);
        rdy_mode = 0;
        rdy_cnt = -1;
        step('0, 1'b0, 1'b1);
        tick();
        tick();
        tick();
        chk("three_words_popped", qa.size(), 13);
        do_reset();
        drain_with('0, 4, 0);

        // Empty window.
        limit = 5'd5;
        random_fill(5, 4);
        drain_with('0, 0, 0);

        // Randomised rounds.
        for (int round = 0; round < 6; round++) begin
            for (int i = 0; i < 40; i++) begin
                limit = 5'($urandom_range(0, 20));
                for (int k = 0; k < NL; k++) begin
                    if ($urandom_range(0, 1) == 0)
                        set_lane(k, int'($urandom_range(0, 65535)) - 32768,
                                 int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
                    else
                        set_lane(k, int'($urandom_range(0, 65535)) - 32768,
                                 int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
                end
                step(NL'($urandom_range(0, (1 << NL) - 1)), ($urandom_range(0, 29) == 0), 1'b0);
            end
            chk("random_drop_sat", int'(a_drop_count), m_drop);
            chk("random_drop_wrap", int'(b_drop_count), m_drop);
            drain_with(NL'($urandom_range(0, (1 << NL) - 1)), int'($urandom_range(0, 14)), 2);
        end

        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
